// File: rtl/reg_file_sb.sv
// Multi-entry register file with one write port, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero entry 0 and a busy scoreboard.
module reg_file_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [DEPTH-1:0]  busy_vec
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic w_we_ok;
  logic w_set_ok;
  logic w_byp_a;
  logic w_byp_b;
  logic w_set_hit_a;
  logic w_set_hit_b;
  logic [WIDTH-1:0] w_st_data_a;
  logic [WIDTH-1:0] w_st_data_b;
  logic w_st_busy_a;
  logic w_st_busy_b;

  // Ignored writes/sets are filtered once here so storage and bypass agree.
  assign w_we_ok  = rst && we && ({1'b0, waddr} < LP_DEPTH)
                    && !((ZERO_REG != 0) && (waddr == '0));
  assign w_set_ok = rst && set_busy && ({1'b0, set_addr} < LP_DEPTH)
                    && !((ZERO_REG != 0) && (set_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we_ok && (waddr == ADDR_W'(i))) begin
          r_mem[i] <= wdata;
        end
        // A newly issued producer outranks the writeback of the previous one.
        if (w_set_ok && (set_addr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_we_ok && (waddr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_st_data_a = '0;
    w_st_data_b = '0;
    w_st_busy_a = 1'b0;
    w_st_busy_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ZERO_REG == 0) || (i != 0)) begin
        if (raddr_a == ADDR_W'(i)) begin
          w_st_data_a = r_mem[i];
          w_st_busy_a = r_busy[i];
        end
        if (raddr_b == ADDR_W'(i)) begin
          w_st_data_b = r_mem[i];
          w_st_busy_b = r_busy[i];
        end
      end
    end
  end

  assign w_byp_a     = (BYPASS != 0) && w_we_ok && (waddr == raddr_a);
  assign w_byp_b     = (BYPASS != 0) && w_we_ok && (waddr == raddr_b);
  assign w_set_hit_a = w_set_ok && (set_addr == raddr_a);
  assign w_set_hit_b = w_set_ok && (set_addr == raddr_b);

  assign rdata_a  = w_byp_a ? wdata : w_st_data_a;
  assign rdata_b  = w_byp_b ? wdata : w_st_data_b;
  assign busy_a   = w_byp_a ? w_set_hit_a : w_st_busy_a;
  assign busy_b   = w_byp_b ? w_set_hit_b : w_st_busy_b;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default, no-zero/no-bypass and DEPTH=6 instances
// share one stimulus stream; each check is an immediate assertion.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic        set_busy;
  logic [2:0]  set_addr;

  logic [15:0] d_rdata_a, d_rdata_b;
  logic        d_busy_a, d_busy_b;
  logic [7:0]  d_busy_vec;
  logic [15:0] n_rdata_a, n_rdata_b;
  logic        n_busy_a, n_busy_b;
  logic [7:0]  n_busy_vec;
  logic [15:0] s_rdata_a, s_rdata_b;
  logic        s_busy_a, s_busy_b;
  logic [5:0]  s_busy_vec;

  int tests_run;
  int tests_failed;

  reg_file_sb u_def (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(d_rdata_a), .rdata_b(d_rdata_b),
    .set_busy(set_busy), .set_addr(set_addr), .busy_a(d_busy_a), .busy_b(d_busy_b),
    .busy_vec(d_busy_vec)
  );

  reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) u_nzb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(n_rdata_a), .rdata_b(n_rdata_b),
    .set_busy(set_busy), .set_addr(set_addr), .busy_a(n_busy_a), .busy_b(n_busy_b),
    .busy_vec(n_busy_vec)
  );

  reg_file_sb #(.DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(s_rdata_a), .rdata_b(s_rdata_b),
    .set_busy(set_busy), .set_addr(set_addr), .busy_a(s_busy_a), .busy_b(s_busy_b),
    .busy_vec(s_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; set_busy = 1'b0; set_addr = '0;
    #2;
    check("init_rdata_a", d_rdata_a, 16'h0000);
    check("init_busy_vec", {8'h00, d_busy_vec}, 16'h0000);

    step();
    rst = 1'b1;
    // Write 0xBEEF to entry 3 while also marking it busy.
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; set_busy = 1'b1; set_addr = 3'd3;
    step();
    we = 1'b0; set_busy = 1'b0; raddr_a = 3'd3;
    #1;
    check("pre_rst_rdata3", d_rdata_a, 16'hBEEF);
    check("pre_rst_busy_vec", {8'h00, d_busy_vec}, 16'h0008);

    // Asynchronous reset mid-cycle, with a write pending that must not land.
    rst = 1'b0; we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
    #1;
    check("rst_rdata3", d_rdata_a, 16'h0000);
    check("rst_busy_vec", {8'h00, d_busy_vec}, 16'h0000);
    step();
    rst = 1'b1; we = 1'b0;
    #1;
    check("post_rst_rdata3", d_rdata_a, 16'h0000);
    step();
    check("post_rst_rdata3_b", d_rdata_a, 16'h0000);

    // Back-to-back writes, then two-port read.
    we = 1'b1; waddr = 3'd5; wdata = 16'h1234;
    step();
    waddr = 3'd7; wdata = 16'hABCD;
    step();
    we = 1'b0; raddr_a = 3'd5; raddr_b = 3'd7;
    #1;
    check("rd_a_5", d_rdata_a, 16'h1234);
    check("rd_b_7", d_rdata_b, 16'hABCD);
    raddr_b = 3'd5;
    #1;
    check("rd_same_a", d_rdata_a, 16'h1234);
    check("rd_same_b", d_rdata_b, 16'h1234);

    // Entry 0: hardwired zero vs. ordinary register.
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; set_busy = 1'b1; set_addr = 3'd0;
    step();
    we = 1'b0; set_busy = 1'b0; raddr_a = 3'd0;
    #1;
    check("zr_rdata0", d_rdata_a, 16'h0000);
    check("zr_busy0", {15'd0, d_busy_vec[0]}, 16'h0000);
    check("nz_rdata0", n_rdata_a, 16'hFFFF);
    check("nz_busy0", {15'd0, n_busy_vec[0]}, 16'h0001);

    // Bypass vs. stored-state read.
    we = 1'b1; waddr = 3'd2; wdata = 16'h0011;
    step();
    wdata = 16'h0022; raddr_a = 3'd2;
    #1;
    check("byp_rdata", d_rdata_a, 16'h0022);
    check("byp_busy", {15'd0, d_busy_a}, 16'h0000);
    check("nobyp_rdata", n_rdata_a, 16'h0011);
    step();
    we = 1'b0;
    #1;
    check("nobyp_rdata_next", n_rdata_a, 16'h0022);

    // Scoreboard set / set-wins / clear.
    set_busy = 1'b1; set_addr = 3'd4;
    step();
    set_busy = 1'b0; raddr_a = 3'd4;
    #1;
    check("sb_vec_set", {8'h00, d_busy_vec}, 16'h0010);
    check("sb_busy_a", {15'd0, d_busy_a}, 16'h0001);
    we = 1'b1; waddr = 3'd4; wdata = 16'h4444; set_busy = 1'b1; set_addr = 3'd4;
    #1;
    check("sb_byp_busy_set", {15'd0, d_busy_a}, 16'h0001);
    step();
    set_busy = 1'b0;
    #1;
    check("sb_vec_setwins", {8'h00, d_busy_vec}, 16'h0010);
    check("sb_byp_busy_clr", {15'd0, d_busy_a}, 16'h0000);
    check("sb_vec_not_byp", {8'h00, d_busy_vec}, 16'h0010);
    step();
    we = 1'b0;
    #1;
    check("sb_vec_cleared", {8'h00, d_busy_vec}, 16'h0000);
    check("sb_data4", d_rdata_a, 16'h4444);

    // Set and write on different addresses in the same cycle.
    we = 1'b1; waddr = 3'd6; wdata = 16'h6666; set_busy = 1'b1; set_addr = 3'd1;
    step();
    we = 1'b0; set_busy = 1'b0; raddr_a = 3'd6;
    #1;
    check("diff_vec", {8'h00, d_busy_vec}, 16'h0002);
    check("diff_data6", d_rdata_a, 16'h6666);
    check("d6_diff_vec", {10'd0, s_busy_vec}, 16'h0002);
    we = 1'b1; waddr = 3'd1; wdata = 16'h0101;
    step();
    we = 1'b0;

    // Out-of-range on the DEPTH=6 instance.
    we = 1'b1; waddr = 3'd6; wdata = 16'h5555; set_busy = 1'b1; set_addr = 3'd7;
    raddr_a = 3'd6; raddr_b = 3'd7;
    #1;
    check("d6_oor_byp", s_rdata_a, 16'h0000);
    check("def_inr_byp", d_rdata_a, 16'h5555);
    step();
    we = 1'b0; set_busy = 1'b0;
    #1;
    check("d6_oor_rdata6", s_rdata_a, 16'h0000);
    check("d6_oor_busy7", {15'd0, s_busy_b}, 16'h0000);
    check("d6_oor_vec", {10'd0, s_busy_vec}, 16'h0000);
    check("def_rdata6", d_rdata_a, 16'h5555);
    check("def_busy7", {15'd0, d_busy_b}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-entry register file for the multicycle 16-bit RISC-V datapath; generalises the single clock-enabled register to DEPTH entries.
- One synchronous write port, two combinational read ports, optional write-to-read bypass, optional hardwired-zero entry 0.
- Per-entry busy scoreboard: the control FSM marks a destination busy at issue; writeback clears it, so decode can detect RAW hazards.

Parameters:
WIDTH, 16, data width of each entry
ADDR_W, 3, address width of all address ports
DEPTH, 8, number of implemented entries; must satisfy 2 <= DEPTH <= 2**ADDR_W
ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous reset, active-low; clears all entries and busy bits while low
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
raddr_a  input  ADDR_W  read address, port A
raddr_b  input  ADDR_W  read address, port B
rdata_a  output  WIDTH  read data, port A (combinational)
rdata_b  output  WIDTH  read data, port B (combinational)
set_busy  input  1  mark entry set_addr busy
set_addr  input  ADDR_W  scoreboard set address
busy_a  output  1  busy status of raddr_a (combinational)
busy_b  output  1  busy status of raddr_b (combinational)
busy_vec  output  DEPTH  all busy bits, bit i = entry i (registered)

Behaviour:
- Reset (rst low, asynchronous): every entry = 0 and every busy bit = 0 immediately, held while low. rdata_a/b = 0, busy_a/b = 0, busy_vec = 0.
- Write: at posedge with rst high and we = 1, entry[waddr] <= wdata. The same edge clears busy[waddr]. This is the writeback event.
- A write is ignored and changes no state when waddr >= DEPTH, or when ZERO_REG = 1 and waddr = 0.
- Set busy: at posedge with set_busy = 1, busy[set_addr] <= 1.
- set_busy is ignored when set_addr >= DEPTH, or when ZERO_REG = 1 and set_addr = 0.
- Simultaneous set_busy and we on the same address: set wins and the busy bit ends at 1, because a new producer was issued. The data write still occurs.
- Simultaneous set and we on different addresses: both take effect.
- Read: rdata_x = entry[raddr_x] when raddr_x < DEPTH, otherwise 0. When ZERO_REG = 1 and raddr_x = 0, rdata_x = 0.
- Latency: reads are zero-cycle (combinational); writes are visible the cycle after the edge.
- Bypass (BYPASS = 1): when we = 1, waddr = raddr_x and the write is not ignored, rdata_x = wdata in the same cycle. In that cycle busy_x = 0 unless set_busy targets the same address, in which case busy_x = 1.
- BYPASS = 0: rdata_x and busy_x reflect stored state only.
- busy_x = busy[raddr_x]; 0 for an out-of-range address, and 0 for entry 0 when ZERO_REG = 1. busy_vec reflects stored bits only and is never bypassed.
- Both read ports may address the same entry, and either may equal waddr. There are no port conflicts.
- Reset asserted mid-write: reset dominates and no write takes effect. Release of reset is synchronous to operation: the first posedge with rst high performs normal updates.
- No X propagation: out-of-range addresses produce defined 0 outputs.

Test Plan:
- Reset: drive rst low mid-run after writing 0xBEEF to entry 3 -> rdata_a(raddr_a=3) = 0x0000 immediately, busy_vec = 8'h00. Release reset; entry 3 stays 0x0000.
- Write/read: write 0x1234 to entry 5, then 0xABCD to entry 7 on consecutive cycles -> next cycle rdata_a(5) = 0x1234 and rdata_b(7) = 0xABCD together. Repeat with raddr_a = raddr_b = 5 -> both ports = 0x1234.
- Zero register (ZERO_REG = 1): write 0xFFFF to entry 0 with set_busy/set_addr = 0 -> rdata_a(0) = 0x0000, busy_vec[0] = 0. Rerun with ZERO_REG = 0 -> rdata_a(0) = 0xFFFF, busy_vec[0] = 1.
- Bypass (BYPASS = 1): entry 2 holds 0x0011, raddr_a = 2, we = 1, wdata = 0x0022 -> rdata_a = 0x0022 in the same cycle. With BYPASS = 0, rdata_a = 0x0011 in that cycle and 0x0022 the next cycle.
- Scoreboard: set_busy entry 4 -> busy_vec = 8'h10 and busy_a(4) = 1 the next cycle. Write entry 4 with set_busy entry 4 in the same cycle -> busy stays 1. Write entry 4 alone -> busy_vec = 8'h00.
- Out of range: DEPTH = 6, ADDR_W = 3; write 0x5555 to address 6, set_busy address 7 -> no state change, rdata_a(6) = 0x0000, busy_b(7) = 0, busy_vec = 6'b000000.
